mtm_alu_deserializer: RTL
=========================

MTM_ALU_DESERIALIZER -- requirements
Module: mtm_alu_deserializer

Interface
REQ-001 Parameters: none; all frame constants come from mtm_Alu_pkg.
REQ-002 clk  input  1  single clock; all sampling on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 sin  input  1  serial request line; idle high; one bit per clk.
REQ-005 valid  output  1  one-cycle pulse; a complete request is decoded.
REQ-006 B  output  32  operand B, first four data bytes, MSB byte first.
REQ-007 A  output  32  operand A, next four data bytes, MSB byte first.
REQ-008 op  output  3  operation code from the CMD packet.
REQ-009 err_flags  output  3  [2]=ERR_DATA, [1]=ERR_CRC, [0]=ERR_OP.

Function
REQ-010 Packet format SHALL be 11 bits: start(0), type (0=DATA, 1=CMD), payload d7..d0 (MSB first), stop(1).
REQ-011 Request format SHALL be 8 DATA packets (B3,B2,B1,B0,A3,A2,A1,A0) followed by 1 CMD packet with payload {1'b0, op[2:0], crc[3:0]}.
REQ-012 FSM states SHALL be IDLE, TYPE, PAYLOAD, STOP; transitions:
- IDLE->TYPE on sin=0.
- TYPE->PAYLOAD after one cycle.
- PAYLOAD->STOP after 8 payload bits.
- STOP->IDLE after one cycle.
REQ-013 DATA packets SHALL be shifted into a 64-bit register; data-packet counter SHALL saturate at 15.
REQ-014 CRC SHALL be CRC-4, polynomial x^4+x+1, initial value 0, computed over the 68-bit vector {B, A, 1'b1, op}, MSB first.
REQ-015 Valid op codes SHALL be 000 (AND), 001 (OR), 100 (ADD), 101 (SUB).
REQ-016 On a CMD stop bit, error priority SHALL be:
- ERR_DATA if data count != 8.
- else ERR_CRC if received crc != computed crc.
- else ERR_OP if op is invalid.
- At most one flag set.
REQ-017 valid SHALL assert for exactly one cycle, the cycle after the CMD stop bit is sampled (latency 1 clk from stop bit); B/A/op/err_flags SHALL update in that same cycle.
REQ-018 B/A/op/err_flags SHALL hold their values until the next valid pulse.
REQ-019 On an ERR_DATA result, B and A SHALL be driven 0 and op SHALL carry the received value.
REQ-020 Stop bit sampled as 0 (DATA or CMD) SHALL produce a valid pulse with err_flags=100 and discard the partial request.
REQ-021 After any CMD packet (good or bad), the data counter and shift register SHALL clear; the next start bit begins a new request.
REQ-022 More than 8 DATA packets before a CMD SHALL yield ERR_DATA; the extra bytes SHALL NOT corrupt internal state beyond saturation.
REQ-023 A start bit SHALL be accepted in the cycle immediately after a stop bit (back-to-back packets, no idle gap required).

Reset
REQ-024 rst_n low SHALL asynchronously force: state IDLE; counters 0; shift register 0; valid=0; B=0; A=0; op=0; err_flags=000.
REQ-025 Reset mid-packet or mid-request SHALL discard all partial data with no valid pulse; after release, the first sin=0 in IDLE SHALL be a start bit.

Structure
REQ-026 mtm_Alu_pkg SHALL hold:
- FSM state enum
- op enum (AND, OR, ADD, SUB)
- err_flags bit indices
- packet type constants
- CRC-4 function
REQ-027 The CRC-4 calculation SHALL be implemented as one sub-module, mtm_alu_crc4, combinational over the 68-bit vector.
REQ-028 The module SHALL be synthesizable, with single-clock registers only and no latches.

Verification
REQ-029 B=0x00000001, A=0x00000002, op=100, correct CRC -> one valid pulse; B=1, A=2, op=100, err_flags=000.
REQ-030 B=0xFFFFFFFF, A=0x12345678, op=000, CRC bit0 flipped -> err_flags=010, B/A as received.
REQ-031 7 DATA packets then CMD op=001 -> err_flags=100, B=0, A=0; the next correct request decodes with err_flags=000.
REQ-032 8 DATA packets, op=010, correct CRC -> err_flags=001.
REQ-033 rst_n pulsed low during the 5th DATA packet -> no valid pulse and outputs 0; a following complete request decodes correctly.
REQ-034 DATA packet with stop bit 0 -> valid pulse with err_flags=100; back-to-back correct requests with zero idle gap -> two valid pulses 99 clk apart.

Source files
------------

// File: rtl/mtm_alu_deserializer_pkg.sv
// mtm_Alu_pkg: shared constants, types and helpers for the serial ALU request
// deserializer.
//   - state_t     : deserializer FSM states
//   - op_t        : supported ALU operation codes
//   - ERR_*_BIT   : bit positions inside err_flags
//   - PKT_*       : packet type bit values
//   - crc4_calc() : CRC-4 (x^4+x+1, init 0, MSB first) over a 68-bit vector
//   - op_is_valid(): true for the four supported op codes
package mtm_Alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TYPE    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_STOP    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_t;

  localparam int ERR_DATA_BIT = 2;
  localparam int ERR_CRC_BIT  = 1;
  localparam int ERR_OP_BIT   = 0;

  // Result reported for a framing error (stop bit sampled low).
  localparam logic [2:0] ERR_DATA_ONLY = 3'b100;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CMD  = 1'b1;

  // Number of DATA packets in a well-formed request, and counter ceiling.
  localparam logic [3:0] DATA_PKTS = 4'd8;
  localparam logic [3:0] CNT_MAX   = 4'd15;

  // Bit-serial LFSR form: feedback = msb ^ data bit, taps at x^1 and x^0.
  function automatic logic [3:0] crc4_calc(input logic [67:0] d);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ d[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic op_is_valid(input logic [2:0] o);
    logic ok;
    case (o)
      OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
      default:                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mtm_alu_deserializer_crc4.sv
// mtm_alu_crc4: purely combinational CRC-4 over the 68-bit request vector
// {B, A, 1'b1, op}.
//   data : input  68-bit vector, MSB processed first
//   crc  : output 4-bit CRC remainder
module mtm_alu_crc4
  import mtm_Alu_pkg::*;
(
  input  logic [67:0] data,
  output logic [3:0]  crc
);

  // CRC of the whole vector in one combinational step.
  always_comb begin
    crc = crc4_calc(data);
  end

endmodule

// File: rtl/mtm_alu_deserializer.sv
// mtm_alu_deserializer: receives 11-bit serial packets (start, type, 8 payload
// bits MSB first, stop) and assembles 8 DATA packets plus 1 CMD packet into a
// decoded ALU request with error classification.
//   clk       : input  single clock, rising-edge sampling
//   rst_n     : input  asynchronous active-low reset
//   sin       : input  serial line, idle high
//   valid     : output one-cycle pulse when a request result is presented
//   B, A      : output 32-bit operands (zero on ERR_DATA)
//   op        : output received 3-bit op code
//   err_flags : output {ERR_DATA, ERR_CRC, ERR_OP}, at most one set
module mtm_alu_deserializer
  import mtm_Alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  output logic        valid,
  output logic [31:0] B,
  output logic [31:0] A,
  output logic [2:0]  op,
  output logic [2:0]  err_flags
);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  bit_cnt_r;
  logic        type_r;
  logic [7:0]  pay_r;
  logic [63:0] shift_r;
  logic [3:0]  data_cnt_r;

  logic        valid_r;
  logic [31:0] b_r;
  logic [31:0] a_r;
  logic [2:0]  op_r;
  logic [2:0]  err_r;

  logic [2:0]  rx_op_s;
  logic [3:0]  rx_crc_s;
  logic [3:0]  crc_calc_s;
  logic [2:0]  res_err_s;
  logic [31:0] res_b_s;
  logic [31:0] res_a_s;

  // CMD payload is {1'b0, op[2:0], crc[3:0]}; fields are only meaningful in STOP.
  assign rx_op_s  = pay_r[6:4];
  assign rx_crc_s = pay_r[3:0];

  mtm_alu_crc4 u_crc4 (
    .data ({shift_r, 1'b1, rx_op_s}),
    .crc  (crc_calc_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a packet occupies exactly 11 cycles.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!sin) begin
          state_nxt_s = ST_TYPE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_TYPE: state_nxt_s = ST_PAYLOAD;
      ST_PAYLOAD: begin
        if (bit_cnt_r == 3'd7) begin
          state_nxt_s = ST_STOP;
        end else begin
          state_nxt_s = ST_PAYLOAD;
        end
      end
      ST_STOP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Request classification for a CMD packet with a good stop bit, in priority order.
  always_comb begin
    res_err_s = 3'b000;
    res_b_s   = shift_r[63:32];
    res_a_s   = shift_r[31:0];
    if (data_cnt_r != DATA_PKTS) begin
      res_err_s[ERR_DATA_BIT] = 1'b1;
      res_b_s                 = 32'h0000_0000;
      res_a_s                 = 32'h0000_0000;
    end else if (rx_crc_s != crc_calc_s) begin
      res_err_s[ERR_CRC_BIT] = 1'b1;
    end else if (!op_is_valid(rx_op_s)) begin
      res_err_s[ERR_OP_BIT] = 1'b1;
    end else begin
      res_err_s = 3'b000;
    end
  end

  // Packet datapath, request accumulation and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= 3'd0;
      type_r     <= 1'b0;
      pay_r      <= 8'h00;
      shift_r    <= 64'h0;
      data_cnt_r <= 4'd0;
      valid_r    <= 1'b0;
      b_r        <= 32'h0000_0000;
      a_r        <= 32'h0000_0000;
      op_r       <= 3'b000;
      err_r      <= 3'b000;
    end else begin
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: bit_cnt_r <= 3'd0;
        ST_TYPE: begin
          type_r    <= sin;
          bit_cnt_r <= 3'd0;
        end
        ST_PAYLOAD: begin
          pay_r     <= {pay_r[6:0], sin};
          bit_cnt_r <= bit_cnt_r + 3'd1;
        end
        ST_STOP: begin
          if (!sin) begin
            // Framing error: report and drop whatever was collected so far.
            valid_r    <= 1'b1;
            b_r        <= 32'h0000_0000;
            a_r        <= 32'h0000_0000;
            op_r       <= (type_r == PKT_DATA) ? 3'b000 : rx_op_s;
            err_r      <= ERR_DATA_ONLY;
            shift_r    <= 64'h0;
            data_cnt_r <= 4'd0;
          end else if (type_r == PKT_CMD) begin
            valid_r    <= 1'b1;
            b_r        <= res_b_s;
            a_r        <= res_a_s;
            op_r       <= rx_op_s;
            err_r      <= res_err_s;
            shift_r    <= 64'h0;
            data_cnt_r <= 4'd0;
          end else begin
            // Surplus DATA packets keep shifting but the count pins at the ceiling,
            // so the request still classifies as ERR_DATA.
            shift_r <= {shift_r[55:0], pay_r};
            if (data_cnt_r != CNT_MAX) begin
              data_cnt_r <= data_cnt_r + 4'd1;
            end
          end
        end
        default: bit_cnt_r <= 3'd0;
      endcase
    end
  end

  assign valid     = valid_r;
  assign B         = b_r;
  assign A         = a_r;
  assign op        = op_r;
  assign err_flags = err_r;

endmodule
